controle_multiciclo: RTL

CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

---
 rtl/controle_multiciclo_pkg.sv | 65 ++++++
 rtl/decodificador_instrucao.sv | 56 +++++
 rtl/controle_multiciclo.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/controle_multiciclo_pkg.sv
// Shared definitions for the multicycle control unit.
// Holds the FSM state encoding, the decoded instruction classes, the opcode
// and funct constants of the supported subset, the ALU operation codes (the
// same codes the ALU uses), and the write-back / immediate-format selects.
package controle_multiciclo_pkg;

  typedef enum logic [2:0] {
    EST_BUSCA      = 3'd0,
    EST_DECODIFICA = 3'd1,
    EST_EXECUTA    = 3'd2,
    EST_MEMORIA    = 3'd3,
    EST_ESCRITA    = 3'd4,
    EST_ERRO       = 3'd5
  } estado_t;

  typedef enum logic [2:0] {
    CLASSE_R,
    CLASSE_I,
    CLASSE_LW,
    CLASSE_SW,
    CLASSE_BEQ,
    CLASSE_INVALIDA
  } classe_t;

  // Opcodes of the supported instruction groups
  localparam logic [6:0] OP_TIPO_R = 7'b0110011;
  localparam logic [6:0] OP_TIPO_I = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // funct3 / funct7 values
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU operation codes
  localparam logic [3:0] ULA_AND = 4'b0000;
  localparam logic [3:0] ULA_OR  = 4'b0001;
  localparam logic [3:0] ULA_ADD = 4'b0010;
  localparam logic [3:0] ULA_SRL = 4'b0101;
  localparam logic [3:0] ULA_SUB = 4'b0110;

  // Write-back source and immediate format selects
  localparam logic [1:0] WB_ULA = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] IMM_I  = 2'b00;
  localparam logic [1:0] IMM_S  = 2'b01;
  localparam logic [1:0] IMM_B  = 2'b10;

  // Immediate format implied by an instruction class (R-type has none -> 00)
  function automatic logic [1:0] formato_imediato(input classe_t c);
    case (c)
      CLASSE_SW:  return IMM_S;
      CLASSE_BEQ: return IMM_B;
      default:    return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/decodificador_instrucao.sv
// Combinational instruction decoder.
// Maps opcode/funct3/funct7 to an instruction class and the ALU operation.
// Ports:
//   codigo_operacao, funcao3, funcao7 : IR fields
//   classe                            : decoded class (CLASSE_INVALIDA if unsupported)
//   operacao_ula                      : ALU code used in EXECUTA
module decodificador_instrucao
  import controle_multiciclo_pkg::*;
(
  input  logic [6:0] codigo_operacao,
  input  logic [2:0] funcao3,
  input  logic [6:0] funcao7,
  output classe_t    classe,
  output logic [3:0] operacao_ula
);

  always_comb begin
    classe       = CLASSE_INVALIDA;
    operacao_ula = ULA_ADD;
    case (codigo_operacao)
      OP_TIPO_R: begin
        if (funcao7 == F7_BASE) begin
          case (funcao3)
            F3_ADD: begin classe = CLASSE_R; operacao_ula = ULA_ADD; end
            F3_AND: begin classe = CLASSE_R; operacao_ula = ULA_AND; end
            F3_OR:  begin classe = CLASSE_R; operacao_ula = ULA_OR;  end
            F3_SRL: begin classe = CLASSE_R; operacao_ula = ULA_SRL; end
            default: ;
          endcase
        end else if (funcao7 == F7_ALT && funcao3 == F3_ADD) begin
          classe       = CLASSE_R;
          operacao_ula = ULA_SUB;
        end
      end
      // funct7 carries immediate bits for I-type, so it is not inspected
      OP_TIPO_I: begin
        case (funcao3)
          F3_ADD: begin classe = CLASSE_I; operacao_ula = ULA_ADD; end
          F3_AND: begin classe = CLASSE_I; operacao_ula = ULA_AND; end
          F3_OR:  begin classe = CLASSE_I; operacao_ula = ULA_OR;  end
          default: ;
        endcase
      end
      OP_LOAD:   if (funcao3 == F3_WORD) classe = CLASSE_LW;
      OP_STORE:  if (funcao3 == F3_WORD) classe = CLASSE_SW;
      OP_BRANCH: begin
        if (funcao3 == F3_BEQ) begin
          classe       = CLASSE_BEQ;
          operacao_ula = ULA_SUB;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control unit FSM (BUSCA/DECODIFICA/EXECUTA/MEMORIA/ESCRITA/ERRO).
// Ports:
//   clk, reset (async, active-low)
//   codigo_operacao, funcao3, funcao7 : IR fields;  zero : ALU result == 0
//   mem_pronta                        : memory finished current access
//   escrever_pc/ir/registrador/memoria, ler_memoria : datapath enables
//   fonte_ula, pc_desvio, operacao_ula, memoria_para_registrador,
//   fonte_imediato                    : datapath selects
//   estado                            : current state
//   instrucao_invalida                : sticky unsupported-instruction flag
//   instrucoes_concluidas             : retired instruction count (wraps)
module controle_multiciclo
  import controle_multiciclo_pkg::*;
#(
  parameter int LIMITE_ESPERA = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  codigo_operacao,
  input  logic [2:0]  funcao3,
  input  logic [6:0]  funcao7,
  input  logic        zero,
  input  logic        mem_pronta,
  output logic        escrever_pc,
  output logic        escrever_ir,
  output logic        escrever_registrador,
  output logic        ler_memoria,
  output logic        escrever_memoria,
  output logic        fonte_ula,
  output logic        pc_desvio,
  output logic [3:0]  operacao_ula,
  output logic [1:0]  memoria_para_registrador,
  output logic [1:0]  fonte_imediato,
  output logic [2:0]  estado,
  output logic        instrucao_invalida,
  output logic [31:0] instrucoes_concluidas
);

  localparam int            CW       = $clog2(LIMITE_ESPERA + 1);
  localparam logic [CW-1:0] LIMITE_W = CW'(LIMITE_ESPERA);

  estado_t       estado_q, estado_d;
  logic [CW-1:0] espera_q, espera_d, espera_inc;
  logic [31:0]   concluidas_q, concluidas_d;
  logic          invalida_q, invalida_d;
  logic          estouro;

  classe_t    classe;
  logic [3:0] op_decod;

  decodificador_instrucao u_decod (
    .codigo_operacao (codigo_operacao),
    .funcao3         (funcao3),
    .funcao7         (funcao7),
    .classe          (classe),
    .operacao_ula    (op_decod)
  );

  // Reaching the limit on this cycle; mem_pronta is checked first so a
  // completion on the limit cycle still counts as success.
  assign espera_inc = espera_q + CW'(1);
  assign estouro    = (espera_inc == LIMITE_W);

  always_comb begin
    estado_d                 = estado_q;
    espera_d                 = '0;
    invalida_d               = invalida_q;
    concluidas_d             = concluidas_q;
    escrever_pc              = 1'b0;
    escrever_ir              = 1'b0;
    escrever_registrador     = 1'b0;
    ler_memoria              = 1'b0;
    escrever_memoria         = 1'b0;
    fonte_ula                = 1'b0;
    pc_desvio                = 1'b0;
    operacao_ula             = 4'b0000;
    memoria_para_registrador = WB_ULA;
    fonte_imediato           = IMM_I;

    case (estado_q)
      EST_BUSCA: begin
        ler_memoria = 1'b1;
        if (mem_pronta) begin
          escrever_ir = 1'b1;
          escrever_pc = 1'b1;
          estado_d    = EST_DECODIFICA;
        end else if (estouro) begin
          estado_d = EST_ERRO;
        end else begin
          espera_d = espera_inc;
        end
      end
      EST_DECODIFICA: begin
        fonte_imediato = formato_imediato(classe);
        if (classe == CLASSE_INVALIDA) begin
          estado_d   = EST_ERRO;
          invalida_d = 1'b1;
        end else begin
          estado_d = EST_EXECUTA;
        end
      end
      EST_EXECUTA: begin
        fonte_imediato = formato_imediato(classe);
        operacao_ula   = op_decod;
        case (classe)
          CLASSE_R: estado_d = EST_ESCRITA;
          CLASSE_I: begin fonte_ula = 1'b1; estado_d = EST_ESCRITA; end
          CLASSE_LW, CLASSE_SW: begin fonte_ula = 1'b1; estado_d = EST_MEMORIA; end
          CLASSE_BEQ: begin
            pc_desvio   = zero;
            escrever_pc = zero;
            estado_d    = EST_BUSCA;
          end
          // IR changed under us; treat like an undecodable instruction
          default: begin estado_d = EST_ERRO; invalida_d = 1'b1; end
        endcase
      end
      EST_MEMORIA: begin
        fonte_imediato   = formato_imediato(classe);
        ler_memoria      = (classe == CLASSE_LW);
        escrever_memoria = (classe == CLASSE_SW);
        if (mem_pronta) begin
          estado_d = (classe == CLASSE_LW) ? EST_ESCRITA : EST_BUSCA;
        end else if (estouro) begin
          estado_d = EST_ERRO;
        end else begin
          espera_d = espera_inc;
        end
      end
      EST_ESCRITA: begin
        escrever_registrador     = 1'b1;
        memoria_para_registrador = (classe == CLASSE_LW) ? WB_MEM : WB_ULA;
        estado_d                 = EST_BUSCA;
      end
      default: estado_d = EST_ERRO;   // ERRO is absorbing, all outputs 0
    endcase

    if (estado_q != EST_BUSCA && estado_d == EST_BUSCA)
      concluidas_d = concluidas_q + 32'd1;

    // Reset must silence the datapath immediately, not one edge later
    if (!reset) begin
      escrever_pc              = 1'b0;
      escrever_ir              = 1'b0;
      escrever_registrador     = 1'b0;
      ler_memoria              = 1'b0;
      escrever_memoria         = 1'b0;
      fonte_ula                = 1'b0;
      pc_desvio                = 1'b0;
      operacao_ula             = 4'b0000;
      memoria_para_registrador = 2'b00;
      fonte_imediato           = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q     <= EST_BUSCA;
      espera_q     <= '0;
      concluidas_q <= '0;
      invalida_q   <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      espera_q     <= espera_d;
      concluidas_q <= concluidas_d;
      invalida_q   <= invalida_d;
    end
  end

  assign estado                = estado_q;
  assign instrucao_invalida    = invalida_q;
  assign instrucoes_concluidas = concluidas_q;

endmodule
